// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage: PC register and instruction-fetch front end (IF -> IF/ID).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00400030,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
);

  localparam logic [31:0] c_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] c_PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        obuf_valid_q, obuf_valid_d;
  logic [31:0] obuf_pc_q, obuf_pc_d;
  logic [31:0] obuf_p4_q, obuf_p4_d;
  logic [31:0] obuf_instr_q, obuf_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic w_handshake;
  assign w_handshake = obuf_valid_q & if_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    obuf_valid_d = obuf_valid_q;
    obuf_pc_d    = obuf_pc_q;
    obuf_p4_d    = obuf_p4_q;
    obuf_instr_d = obuf_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (w_handshake) begin
      obuf_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      // Redirect wins over everything; an in-flight request must have its
      // stale response swallowed, a response arriving now is simply ignored.
      pc_d         = redirect_pc & c_ALIGN_MASK;
      obuf_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (!obuf_valid_q || w_handshake) begin
              obuf_valid_d = 1'b1;
              obuf_pc_d    = pc_q;
              obuf_p4_d    = pc_q + c_PC_STEP;
              obuf_instr_d = imem_rdata;
              pc_d         = pc_q + c_PC_STEP;
              state_d      = S_REQ;
            end else begin
              skid_pc_d    = pc_q;
              skid_instr_d = imem_rdata;
              state_d      = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (w_handshake) begin
            obuf_valid_d = 1'b1;
            obuf_pc_d    = skid_pc_q;
            obuf_p4_d    = skid_pc_q + c_PC_STEP;
            obuf_instr_d = skid_instr_q;
            pc_d         = pc_q + c_PC_STEP;
            state_d      = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      obuf_valid_q <= 1'b0;
      obuf_pc_q    <= 32'd0;
      obuf_p4_q    <= 32'd0;
      obuf_instr_q <= NOP_WORD;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= NOP_WORD;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      obuf_valid_q <= obuf_valid_d;
      obuf_pc_q    <= obuf_pc_d;
      obuf_p4_q    <= obuf_p4_d;
      obuf_instr_q <= obuf_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Reset masks the interface immediately, not just from the next edge.
  assign imem_req    = (state_q == S_REQ) & ~rst;
  assign imem_addr   = pc_q;
  assign if_valid    = obuf_valid_q & ~rst;
  assign if_pc       = rst ? 32'd0 : obuf_pc_q;
  assign if_pc_plus4 = rst ? 32'd0 : obuf_p4_q;
  assign if_instr    = if_valid ? obuf_instr_q : NOP_WORD;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage: directed vector table plus randomized run against a
// transaction-level model of fetch_stage. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] c_RESET_PC = 32'h00400030;
  localparam logic [31:0] c_NOP      = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  fetch_stage #(.RESET_PC(c_RESET_PC), .NOP_WORD(c_NOP)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rv;
    logic [31:0] rpc;
    logic        gnt, rvl;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_p4, e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic r, input logic rv, input logic [31:0] rpc,
                   input logic g, input logic rvl, input logic [31:0] rd,
                   input logic rdy, input logic e_req, input logic [31:0] e_addr,
                   input logic e_valid, input logic [31:0] e_pc,
                   input logic [31:0] e_instr);
    vec_t t;
    t.rst = r; t.rv = rv; t.rpc = rpc; t.gnt = g; t.rvl = rvl; t.rdata = rd;
    t.rdy = rdy; t.e_req = e_req; t.e_addr = e_addr; t.e_valid = e_valid;
    t.e_pc = e_pc; t.e_p4 = e_pc + 32'd4; t.e_instr = e_instr;
    vecs.push_back(t);
  endtask

  // Memory contents used by the random run: any fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Reference model state (random run)
  logic [31:0] exp_pc;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        prev_hold;
  logic [31:0] prev_pc, prev_instr;
  int          accepted;

  initial begin
    // rst rv rpc gnt rvl rdata rdy | req addr valid pc instr
    v(1,0,32'h0,0,0,32'h0,0, 0,32'h0,0,32'h0,c_NOP);
    v(1,0,32'h0,0,0,32'h0,0, 0,32'h0,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,1, 1,32'h00400030,0,32'h0,c_NOP);
    v(0,0,32'h0,0,1,32'h20080005,1, 0,32'h00400030,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,0, 1,32'h00400034,1,32'h00400030,32'h20080005);
    v(0,0,32'h0,0,1,32'hAAAA0001,0, 0,32'h00400034,1,32'h00400030,32'h20080005);
    for (int i = 0; i < 3; i++)
      v(0,0,32'h0,0,0,32'h0,0, 0,32'h00400034,1,32'h00400030,32'h20080005);
    v(0,0,32'h0,0,0,32'h0,1, 0,32'h00400034,1,32'h00400030,32'h20080005);
    v(0,0,32'h0,1,0,32'h0,1, 1,32'h00400038,1,32'h00400034,32'hAAAA0001);
    // redirect while 0x00400038 outstanding
    v(0,1,32'h00400100,0,0,32'h0,1, 0,32'h00400038,0,32'h0,c_NOP);
    v(0,0,32'h0,0,1,32'hBAD00038,1, 0,32'h00400100,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,1, 1,32'h00400100,0,32'h0,c_NOP);
    v(0,0,32'h0,0,1,32'hCCCC0100,1, 0,32'h00400100,0,32'h0,c_NOP);
    v(0,0,32'h0,0,0,32'h0,1, 1,32'h00400104,1,32'h00400100,32'hCCCC0100);
    // misaligned redirect in REQ without grant
    v(0,1,32'h00400103,0,0,32'h0,1, 1,32'h00400104,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,1, 1,32'h00400100,0,32'h0,c_NOP);
    v(0,0,32'h0,0,1,32'hDDDD0100,1, 0,32'h00400100,0,32'h0,c_NOP);
    v(0,0,32'h0,0,0,32'h0,1, 1,32'h00400104,1,32'h00400100,32'hDDDD0100);
    // wrap at the top of the address space
    v(0,1,32'hFFFFFFFC,0,0,32'h0,1, 1,32'h00400104,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,1, 1,32'hFFFFFFFC,0,32'h0,c_NOP);
    v(0,0,32'h0,0,1,32'hEEEE0000,1, 0,32'hFFFFFFFC,0,32'h0,c_NOP);
    v(0,0,32'h0,0,0,32'h0,0, 1,32'h00000000,1,32'hFFFFFFFC,32'hEEEE0000);
    v(0,0,32'h0,1,0,32'h0,0, 1,32'h00000000,1,32'hFFFFFFFC,32'hEEEE0000);
    // reset during WAIT
    v(1,0,32'h0,0,0,32'h0,0, 0,32'h0,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,0, 1,32'h00400030,0,32'h0,c_NOP);
    v(0,0,32'h0,0,1,32'h11110030,0, 0,32'h00400030,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,0, 1,32'h00400034,1,32'h00400030,32'h11110030);
    v(0,0,32'h0,0,1,32'h22220034,0, 0,32'h00400034,1,32'h00400030,32'h11110030);
    // reset during FULL: skid must not survive
    v(1,0,32'h0,0,0,32'h0,0, 0,32'h0,0,32'h0,c_NOP);
    v(0,0,32'h0,0,0,32'h0,1, 1,32'h00400030,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,1, 1,32'h00400030,0,32'h0,c_NOP);
    v(0,0,32'h0,0,1,32'h33330030,1, 0,32'h00400030,0,32'h0,c_NOP);
    v(0,0,32'h0,0,0,32'h0,1, 1,32'h00400034,1,32'h00400030,32'h33330030);
    // two redirects while one request is outstanding: exactly one drop
    v(1,0,32'h0,0,0,32'h0,0, 0,32'h0,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,1, 1,32'h00400030,0,32'h0,c_NOP);
    v(0,1,32'h00400200,0,0,32'h0,1, 0,32'h00400030,0,32'h0,c_NOP);
    v(0,1,32'h00400300,0,0,32'h0,1, 0,32'h00400200,0,32'h0,c_NOP);
    v(0,0,32'h0,0,1,32'hBAD00030,1, 0,32'h00400300,0,32'h0,c_NOP);
    v(0,0,32'h0,1,0,32'h0,1, 1,32'h00400300,0,32'h0,c_NOP);
    v(0,0,32'h0,0,1,32'h44440300,1, 0,32'h00400300,0,32'h0,c_NOP);
    v(0,0,32'h0,0,0,32'h0,1, 1,32'h00400304,1,32'h00400300,32'h44440300);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvl; imem_rdata = vecs[i].rdata;
      if_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("vec%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d if_instr", i), if_instr, vecs[i].e_instr);
      if (!vecs[i].rst)
        chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].rst || vecs[i].e_valid)
        chk($sformatf("vec%0d if_pc", i), if_pc, vecs[i].e_pc);
      if (vecs[i].e_valid)
        chk($sformatf("vec%0d if_pc_plus4", i), if_pc_plus4, vecs[i].e_p4);
      @(posedge clk); #1;
    end

    // Randomized run against the transaction-level model
    exp_pc = c_RESET_PC; mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'd0;
    prev_hold = 1'b0; prev_pc = 32'd0; prev_instr = 32'd0; accepted = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      #1;
      redirect_valid = !rst && ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc = $urandom;
      endcase
      imem_rvalid = !rst && mem_busy && (mem_cnt == 0);
      imem_rdata  = imem_rvalid ? mem_word(mem_addr) : $urandom;
      imem_gnt    = imem_req && ($urandom_range(0, 9) < 6);
      if_ready    = ($urandom_range(0, 9) < 6);
      #1;
      if (rst) begin
        chk("rst if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst if_pc", if_pc, 32'd0);
        chk("rst if_instr", if_instr, c_NOP);
        chk("rst imem_req", {31'd0, imem_req}, 32'd0);
      end else begin
        if (imem_req) chk("req while outstanding", {31'd0, mem_busy}, 32'd0);
        if (prev_hold) begin
          chk("stall valid held", {31'd0, if_valid}, 32'd1);
          chk("stall pc held", if_pc, prev_pc);
          chk("stall instr held", if_instr, prev_instr);
        end
        if (if_valid) begin
          chk("rand pc_plus4", if_pc_plus4, if_pc + 32'd4);
          chk("rand instr", if_instr, mem_word(if_pc));
        end else begin
          chk("rand idle instr", if_instr, c_NOP);
        end
        if (if_valid && if_ready) begin
          chk("rand accepted pc", if_pc, exp_pc);
          exp_pc = exp_pc + 32'd4;
          accepted++;
        end
        if (redirect_valid) exp_pc = redirect_pc & 32'hFFFFFFFC;
      end
      prev_hold  = !rst && if_valid && !if_ready && !redirect_valid;
      prev_pc    = if_pc;
      prev_instr = if_instr;
      if (rst) begin
        exp_pc = c_RESET_PC; mem_busy = 1'b0;
      end else if (imem_rvalid) begin
        mem_busy = 1'b0;
      end else if (imem_gnt) begin
        mem_busy = 1'b1; mem_addr = imem_addr; mem_cnt = $urandom_range(0, 2);
      end else if (mem_busy) begin
        mem_cnt--;
      end
      @(posedge clk); #1;
    end
    chk("accepted enough", {31'd0, accepted >= 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
